// File: rtl/imm_pkg.sv
// Shared definitions for the immediate generator: format codes, skid-buffer
// state encoding and the XLEN-dependent shift-amount width.
package imm_pkg;

    localparam logic [2:0] IMM_I     = 3'b000;
    localparam logic [2:0] IMM_SHAMT = 3'b001;
    localparam logic [2:0] IMM_B     = 3'b010;
    localparam logic [2:0] IMM_J     = 3'b011;
    localparam logic [2:0] IMM_U     = 3'b100;
    localparam logic [2:0] IMM_S     = 3'b101;
    localparam logic [2:0] IMM_ZIMM  = 3'b110;
    localparam logic [2:0] IMM_ILL   = 3'b111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    function automatic int shamt_w(input int xlen);
        return (xlen == 64) ? 6 : 5;
    endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational RISC-V immediate extraction: (instr, sel) -> XLEN-wide
// immediate plus an illegal-select flag.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      sel,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    localparam int SHAMT_W = shamt_w(XLEN);

    logic [31:0] raw;
    logic        sext;

    // Every format is first assembled as a 32-bit value; sext decides how it widens.
    always_comb begin
        raw     = '0;
        sext    = 1'b0;
        illegal = 1'b0;
        case (sel)
            IMM_I: begin
                raw  = {{20{instr[31]}}, instr[31:20]};
                sext = 1'b1;
            end
            IMM_SHAMT: begin
                raw[SHAMT_W-1:0] = instr[20 +: SHAMT_W];
            end
            IMM_B: begin
                raw  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                sext = 1'b1;
            end
            IMM_J: begin
                raw  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                sext = 1'b1;
            end
            IMM_U: begin
                raw  = {instr[31:12], 12'b0};
                sext = 1'b1;
            end
            IMM_S: begin
                raw  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                sext = 1'b1;
            end
            IMM_ZIMM: begin
                raw = {27'b0, instr[19:15]};
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        if (sext) begin
            imm = XLEN'($signed(raw));
        end else begin
            imm = XLEN'(raw);
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a two-entry skid buffer on valid/ready.
// Define IMMGEN_ILLEGAL_CHK_EN to build the out_illegal flag and illegal_cnt counter.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [7:0]       illegal_cnt
);

    skid_state_e state_q, state_d;

    logic [XLEN-1:0]  ext_imm;
    logic             ext_illegal;
    logic [XLEN-1:0]  out_imm_q, out_imm_d, skid_imm_q, skid_imm_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d, skid_tag_q, skid_tag_d;

    logic accept, drain;
    logic ld_out_new, ld_out_skid, ld_skid;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr   (in_instr),
        .sel     (in_sel),
        .imm     (ext_imm),
        .illegal (ext_illegal)
    );

    // Ready comes from registered state only, so no comb path from out_ready.
    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        ld_out_new  = 1'b0;
        ld_out_skid = 1'b0;
        ld_skid     = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    ld_out_new = 1'b1;
                    state_d    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && !drain) begin
                    ld_skid = 1'b1;
                    state_d = ST_TWO;
                end else if (accept && drain) begin
                    ld_out_new = 1'b1;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (drain) begin
                    ld_out_skid = 1'b1;
                    state_d     = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_comb begin
        out_imm_d  = out_imm_q;
        out_tag_d  = out_tag_q;
        skid_imm_d = skid_imm_q;
        skid_tag_d = skid_tag_q;
        if (ld_out_new) begin
            out_imm_d = ext_imm;
            out_tag_d = in_tag;
        end else if (ld_out_skid) begin
            out_imm_d = skid_imm_q;
            out_tag_d = skid_tag_q;
        end
        if (ld_skid) begin
            skid_imm_d = ext_imm;
            skid_tag_d = in_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            out_imm_q  <= '0;
            out_tag_q  <= '0;
            skid_imm_q <= '0;
            skid_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            out_imm_q  <= out_imm_d;
            out_tag_q  <= out_tag_d;
            skid_imm_q <= skid_imm_d;
            skid_tag_q <= skid_tag_d;
        end
    end

    assign out_imm = out_imm_q;
    assign out_tag = out_tag_q;

`ifdef IMMGEN_ILLEGAL_CHK_EN
    logic       out_ill_q, out_ill_d, skid_ill_q, skid_ill_d;
    logic [7:0] ill_cnt_q, ill_cnt_d;

    always_comb begin
        out_ill_d  = out_ill_q;
        skid_ill_d = skid_ill_q;
        ill_cnt_d  = ill_cnt_q;
        if (ld_out_new) begin
            out_ill_d = ext_illegal;
        end else if (ld_out_skid) begin
            out_ill_d = skid_ill_q;
        end
        if (ld_skid) begin
            skid_ill_d = ext_illegal;
        end
        if (accept && ext_illegal && (ill_cnt_q != 8'hFF)) begin
            ill_cnt_d = ill_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ill_q  <= 1'b0;
            skid_ill_q <= 1'b0;
            ill_cnt_q  <= '0;
        end else begin
            out_ill_q  <= out_ill_d;
            skid_ill_q <= skid_ill_d;
            ill_cnt_q  <= ill_cnt_d;
        end
    end

    assign out_illegal = out_ill_q;
    assign illegal_cnt = ill_cnt_q;
`else
    logic unused_illegal;
    assign unused_illegal = ext_illegal;
    assign out_illegal    = 1'b0;
    assign illegal_cnt    = 8'd0;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed-vector bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus.
module tb_imm_gen_pipe;

`ifdef IMMGEN_ILLEGAL_CHK_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [2:0]  in_sel;
    logic [31:0] in_tag;

    logic        in_ready32, out_valid32, ill32;
    logic [31:0] imm32, tag32;
    logic [7:0]  cnt32;
    logic        in_ready64, out_valid64, ill64;
    logic [63:0] imm64;
    logic [31:0] tag64;
    logic [7:0]  cnt64;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(imm32), .out_tag(tag32),
        .out_illegal(ill32), .illegal_cnt(cnt32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(imm64), .out_tag(tag64),
        .out_illegal(ill64), .illegal_cnt(cnt64)
    );

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  sel;
        logic [31:0] exp32;
        logic [63:0] exp64;
    } vec_t;

    vec_t vecs[13];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] i_instr(input logic [11:0] imm);
        return {imm, 20'h00093};
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] q[$];
        logic [31:0] t;
        logic        acc, drn, prev_acc;
        int          accepted, cyc;

        vecs[0]  = '{32'hFFF00093, 3'b000, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
        vecs[1]  = '{32'h02A00093, 3'b000, 32'h0000002A, 64'h000000000000002A};
        vecs[2]  = '{32'hFFF00093, 3'b001, 32'h0000001F, 64'h000000000000003F};
        vecs[3]  = '{32'hFDF00093, 3'b001, 32'h0000001F, 64'h000000000000001F};
        vecs[4]  = '{32'hFE000EE3, 3'b010, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC};
        vecs[5]  = '{32'h004000EF, 3'b011, 32'h00000004, 64'h0000000000000004};
        vecs[6]  = '{32'hFFDFF0EF, 3'b011, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC};
        vecs[7]  = '{32'h123450B7, 3'b100, 32'h12345000, 64'h0000000012345000};
        vecs[8]  = '{32'h800000B7, 3'b100, 32'h80000000, 64'hFFFFFFFF80000000};
        vecs[9]  = '{32'hFE112E23, 3'b101, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC};
        vecs[10] = '{32'h00112423, 3'b101, 32'h00000008, 64'h0000000000000008};
        vecs[11] = '{32'hFFFFD073, 3'b110, 32'h0000001F, 64'h000000000000001F};
        vecs[12] = '{32'hFFFFFFFF, 3'b111, 32'h00000000, 64'h0000000000000000};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_instr  = '0;
        in_sel    = '0;
        in_tag    = '0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", out_valid32, 0);
        chk("rst_in_ready", in_ready32, 1);
        chk("rst_out_imm", imm32, 0);
        chk("rst_out_tag", tag32, 0);
        chk("rst_illegal", ill32, 0);
        chk("rst_cnt", cnt32, 0);
        chk("rst_out_valid64", out_valid64, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Format table, one accept per vector with out_ready high
        foreach (vecs[i]) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            in_sel   = vecs[i].sel;
            in_tag   = 32'h100 + i;
            @(negedge clk);
            in_valid = 1'b0;
            $display("vec %0d: instr %h sel %0d -> imm32 %h imm64 %h tag %h",
                     i, vecs[i].instr, vecs[i].sel, imm32, imm64, tag32);
            chk("vec_valid", out_valid32, 1);
            chk("vec_imm32", imm32, vecs[i].exp32);
            chk("vec_imm64", imm64, vecs[i].exp64);
            chk("vec_tag", tag32, 32'h100 + i);
            chk("vec_illegal", ill32, (ILL_EN && vecs[i].sel == 3'b111) ? 1 : 0);
        end
        @(negedge clk);
        chk("table_drained", out_valid32, 0);
        chk("table_cnt", cnt32, ILL_EN ? 1 : 0);

        // Backpressure: tags 1,2 accepted, 3 held off, then released in order
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 3'b000;
        in_tag    = 32'd1;
        in_instr  = i_instr(12'd1);
        @(negedge clk);
        chk("bp_ready_one", in_ready32, 1);
        in_tag   = 32'd2;
        in_instr = i_instr(12'd2);
        @(negedge clk);
        chk("bp_ready_two", in_ready32, 0);
        chk("bp_tag_hold", tag32, 1);
        in_tag   = 32'd3;
        in_instr = i_instr(12'd3);
        @(negedge clk);
        chk("bp_ready_stall", in_ready32, 0);
        chk("bp_tag_stall", tag32, 1);
        chk("bp_imm_stall", imm32, 1);
        out_ready = 1'b1;
        @(negedge clk);
        $display("bp drain: tag %0d", tag32);
        chk("bp_tag2", tag32, 2);
        chk("bp_ready_back", in_ready32, 1);
        @(negedge clk);
        in_valid = 1'b0;
        $display("bp drain: tag %0d", tag32);
        chk("bp_tag3", tag32, 3);
        chk("bp_imm3", imm32, 3);
        @(negedge clk);
        chk("bp_empty", out_valid32, 0);

        // Random handshakes with an order scoreboard
        accepted = 0;
        cyc      = 0;
        prev_acc = 1'b0;
        out_ready = 1'b0;
        while ((accepted < 2000 || q.size() != 0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (prev_acc) in_valid = 1'b0;
            if (!in_valid && accepted < 2000 && $urandom_range(0, 3) != 0) begin
                t        = $urandom;
                in_valid = 1'b1;
                in_tag   = t;
                in_instr = i_instr(t[11:0]);
                in_sel   = 3'b000;
            end
            out_ready = (accepted >= 2000) ? 1'b1 : ($urandom_range(0, 2) != 0);
            chk("rnd_in_ready", in_ready32, (q.size() < 2) ? 1 : 0);
            chk("rnd_out_valid", out_valid32, (q.size() != 0) ? 1 : 0);
            acc = in_valid && in_ready32;
            drn = out_valid32 && out_ready;
            if (drn && q.size() != 0) begin
                t = q.pop_front();
                $display("rnd drain: tag %h imm %h", tag32, imm32);
                chk("rnd_tag", tag32, t);
                chk("rnd_imm", imm32, {{20{t[11]}}, t[11:0]});
            end
            if (acc) begin
                q.push_back(in_tag);
                accepted++;
            end
            prev_acc = acc;
        end
        chk("rnd_timeout", (cyc >= 20000) ? 1 : 0, 0);
        @(negedge clk);
        in_valid = 1'b0;

        // Reset while both entries are held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 32'hA1;
        in_instr  = i_instr(12'hA1);
        @(negedge clk);
        in_tag   = 32'hA2;
        in_instr = i_instr(12'hA2);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_full", in_ready32, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid32, 0);
        chk("mid_rst_imm", imm32, 0);
        chk("mid_rst_tag", tag32, 0);
        chk("mid_rst_ready", in_ready32, 1);
        chk("mid_rst_imm64", imm64, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_tag    = 32'h55;
        in_instr  = i_instr(12'h055);
        @(negedge clk);
        in_valid = 1'b0;
        chk("post_rst_valid", out_valid32, 1);
        chk("post_rst_tag", tag32, 32'h55);
        chk("post_rst_imm", imm32, 32'h55);
        @(negedge clk);
        chk("post_rst_no_stale", out_valid32, 0);

        // Illegal-select burst and counter saturation
        in_valid = 1'b1;
        in_sel   = 3'b111;
        in_instr = 32'hFFFFFFFF;
        in_tag   = 32'hEE;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (k == 100) chk("ill_cnt_100", cnt32, ILL_EN ? 100 : 0);
        end
        in_valid = 1'b0;
        $display("illegal burst: cnt %0d illegal %0d imm %h", cnt32, ill32, imm32);
        chk("ill_cnt_sat", cnt32, ILL_EN ? 255 : 0);
        chk("ill_cnt_sat64", cnt64, ILL_EN ? 255 : 0);
        chk("ill_flag", ill32, ILL_EN ? 1 : 0);
        chk("ill_imm", imm32, 0);
        chk("ill_valid", out_valid32, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
